// File: rtl/fir_sample_src.sv
// Sample feeder for the 4-tap FIR: buffers framed samples in a FIFO, streams them
// one per cycle, appends NTAPS-1 zero flush samples per frame and owns c0..c3.
module fir_sample_src #(
  parameter int DW    = 17,
  parameter int DEPTH = 16,
  parameter int NTAPS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          enable,
  input  logic          coef_wr,
  input  logic [1:0]    coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic          coef_err,
  output logic [DW-1:0] x_in,
  output logic          in_data_vld,
  output logic [DW-1:0] c0,
  output logic [DW-1:0] c1,
  output logic [DW-1:0] c2,
  output logic [DW-1:0] c3,
  output logic          busy,
  output logic          frame_done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = (NTAPS > 2) ? $clog2(NTAPS) : 1;
  localparam logic [CW-1:0]  FULL_CNT   = CW'(DEPTH);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(NTAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic [DW:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           s_ready_q, s_ready_d;
  logic [DW-1:0]  x_in_q, x_in_d;
  logic           vld_q, vld_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic           coef_err_q, coef_err_d;
  logic [DW-1:0]  coef_q [4];
  logic [DW-1:0]  coef_d [4];
  logic           push;
  logic           pop;
  logic [DW:0]    head;

  // FIFO bookkeeping; s_ready is the registered view of the post-edge count
  always_comb begin
    push     = s_valid & s_ready_q;
    head     = mem_q[rd_ptr_q];
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    s_ready_d = (count_d != FULL_CNT);
  end

  // Frame sequencer: stream FIFO entries, then emit the zero flush tail
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    x_in_d       = '0;
    vld_d        = 1'b0;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        if (enable && (count_q != '0)) begin
          pop    = 1'b1;
          x_in_d = head[DW-1:0];
          vld_d  = 1'b1;
          if (head[DW]) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = state_q;
        end
      end
      FLUSH: begin
        // All zeros already out: close the frame whether or not enable is high
        if (flush_cnt_q == FLUSH_LAST) begin
          frame_done_d = 1'b1;
          flush_cnt_d  = '0;
          state_d      = IDLE;
        end else if (enable) begin
          vld_d       = 1'b1;
          flush_cnt_d = flush_cnt_q + FCW'(1);
        end else begin
          flush_cnt_d = flush_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Coefficient writes are only honoured between frames
  always_comb begin
    coef_d     = coef_q;
    coef_err_d = 1'b0;
    if (coef_wr) begin
      if (busy_q) begin
        coef_err_d = 1'b1;
      end else begin
        coef_d[coef_addr] = coef_data;
      end
    end else begin
      coef_err_d = 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

  // Control, output and coefficient registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      s_ready_q    <= 1'b1;
      x_in_q       <= '0;
      vld_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      coef_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      s_ready_q    <= s_ready_d;
      x_in_q       <= x_in_d;
      vld_q        <= vld_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      coef_err_q   <= coef_err_d;
      coef_q       <= coef_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign x_in        = x_in_q;
  assign in_data_vld = vld_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign coef_err    = coef_err_q;
  assign c0          = coef_q[0];
  assign c1          = coef_q[1];
  assign c2          = coef_q[2];
  assign c3          = coef_q[3];

endmodule

// File: tb/tb_fir_sample_src.sv
// Scoreboard bench for fir_sample_src: expected output stream is the accepted
// sample stream with NTAPS-1 zeros inserted after every frame's last sample.
module tb_fir_sample_src;

  localparam int DW    = 17;
  localparam int DEPTH = 16;
  localparam int NTAPS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          enable;
  logic          coef_wr;
  logic [1:0]    coef_addr;
  logic [DW-1:0] coef_data;
  logic          coef_err;
  logic [DW-1:0] x_in;
  logic          in_data_vld;
  logic [DW-1:0] c0, c1, c2, c3;
  logic          busy;
  logic          frame_done;

  fir_sample_src #(.DW(DW), .DEPTH(DEPTH), .NTAPS(NTAPS)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .enable(enable),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .x_in(x_in), .in_data_vld(in_data_vld),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  int frames_exp = 0;
  int frames_seen = 0;
  int vld_total = 0;
  int run_len = 0;
  int last_run = 0;
  int first_vld_cyc = -1;
  int accept_cyc = 0;
  bit prev_vld = 1'b0;
  bit rand_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // Monitor: samples just after each rising edge and checks against the scoreboard
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (in_data_vld === 1'b1) begin
        vld_total++;
        run_len++;
        if (!prev_vld) first_vld_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: x_in=%0h valid with no sample outstanding, required none", x_in);
        end else begin
          e = exp_q.pop_front();
          check("x_in", 64'(x_in), 64'(e));
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        check("x_in_idle_zero", 64'(x_in), 64'd0);
      end
      if (frame_done === 1'b1) begin
        frames_seen++;
        check("frame_done_after_last_zero", 64'({prev_vld, in_data_vld}), 64'd2);
      end
      prev_vld = (in_data_vld === 1'b1);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_en) enable = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit l);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && guard < 1000) begin
      tick();
      guard++;
    end
    if (s_ready === 1'b1) begin
      accept_cyc = cyc + 1;
      exp_q.push_back(d);
      if (l) begin
        for (int i = 0; i < NTAPS - 1; i++) exp_q.push_back('0);
        frames_exp++;
      end
    end else begin
      n_checks++;
      $display("FAIL send_timeout: s_ready=%b, required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while ((exp_q.size() != 0 || frames_seen != frames_exp) && guard < 3000) begin
      tick();
      guard++;
    end
    check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_frames"}, 64'(frames_seen), 64'(frames_exp));
    check({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic coef_write(input logic [1:0] a, input logic [DW-1:0] d, input bit exp_err);
    coef_wr   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_wr = 1'b0;
    check("coef_err", 64'(coef_err), 64'(exp_err));
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_x_in"}, 64'(x_in), 64'd0);
    check({nm, "_vld"}, 64'(in_data_vld), 64'd0);
    check({nm, "_s_ready"}, 64'(s_ready), 64'd1);
    check({nm, "_c0"}, 64'(c0), 64'd0);
    check({nm, "_c1"}, 64'(c1), 64'd0);
    check({nm, "_c2"}, 64'(c2), 64'd0);
    check({nm, "_c3"}, 64'(c3), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_frame_done"}, 64'(frame_done), 64'd0);
    check({nm, "_coef_err"}, 64'(coef_err), 64'd0);
  endtask

  initial begin
    int frame_vals[7] = '{3, 2, 1, 0, 1, 2, 3};
    int a0, v0, f0, len;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; enable = 1'b0;
    coef_wr = 1'b0; coef_addr = 2'd0; coef_data = '0;
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;

    // Coefficient load while idle
    for (int i = 0; i < 4; i++) coef_write(2'(i), DW'(i), 1'b0);
    check("c0_load", 64'(c0), 64'd0);
    check("c1_load", 64'(c1), 64'd1);
    check("c2_load", 64'(c2), 64'd2);
    check("c3_load", 64'(c3), 64'd3);

    // Reference frame, streamed back to back
    enable = 1'b1;
    a0 = 0;
    for (int i = 0; i < 7; i++) begin
      send(DW'(frame_vals[i]), (i == 6));
      if (i == 0) a0 = accept_cyc;
    end
    drain("frame");
    check("first_latency", 64'(first_vld_cyc - a0), 64'd1);
    check("valid_run_len", 64'(last_run), 64'd10);

    // Fill the FIFO with output stalled
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(DW'(100 + i), (i == DEPTH - 1));
    check("full_ready_low", 64'(s_ready), 64'd0);
    s_valid = 1'b1; s_data = 17'd999; s_last = 1'b0;
    tick();
    s_valid = 1'b0; s_data = '0;
    check("refused_still_full", 64'(s_ready), 64'd0);
    enable = 1'b1;
    tick();
    check("ready_after_first_pop", 64'(s_ready), 64'd1);
    drain("full");

    // Coefficient write attempted mid-frame, then between frames
    enable = 1'b0;
    for (int i = 0; i < 4; i++) send(DW'(50 + i), (i == 3));
    enable = 1'b1;
    tick();
    coef_write(2'd2, 17'd7, 1'b1);
    check("c2_guarded", 64'(c2), 64'd2);
    tick();
    check("coef_err_one_cycle", 64'(coef_err), 64'd0);
    drain("coef_stream");
    coef_write(2'd2, 17'd7, 1'b0);
    check("c2_idle_write", 64'(c2), 64'd7);

    // Enable toggling during the flush tail of a single-sample frame
    enable = 1'b0;
    send(17'h1ABCD, 1'b1);
    v0 = vld_total;
    f0 = frames_seen;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      enable = (i % 2 == 1);
      tick();
    end
    enable = 1'b1;
    drain("toggle");
    check("toggle_valid_count", 64'(vld_total - v0), 64'd4);
    check("toggle_frame_count", 64'(frames_seen - f0), 64'd1);

    // Reset in the middle of a flush with samples still buffered
    enable = 1'b0;
    send(17'h00055, 1'b1);
    for (int i = 0; i < 5; i++) send(DW'(60 + i), 1'b0);
    enable = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    frames_exp = frames_seen;
    tick();
    check_reset_vals("mid_reset");
    reset = 1'b0;
    v0 = vld_total;
    f0 = frames_seen;
    repeat (10) tick();
    check("no_valid_after_reset", 64'(vld_total - v0), 64'd0);
    check("no_frame_done_after_reset", 64'(frames_seen - f0), 64'd0);
    send(17'h01234, 1'b1);
    drain("post_reset");

    // Randomised frames, gaps and enable stalls
    rand_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 2) == 0) tick();
        send(DW'($urandom_range(0, (1 << DW) - 1)), (j == len - 1));
      end
    end
    drain("random");
    rand_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
